// File: rtl/rob_commit_unit.sv
// In-order retirement buffer, indexed directly by instruction tag. Retires the oldest
// completed entries in program order, up to COMMIT_WIDTH per cycle.
module rob_commit_unit #(
    parameter int ROB_SIZE_WIDTH         = 4,
    parameter int PHYSICAL_REG_NUM_WIDTH = 6,
    parameter int COMMIT_WIDTH           = 2,
    parameter int COMMIT_TYPE_WIDTH      = 2
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                flush,
    input  logic                                                dispatch_valid,
    input  logic [ROB_SIZE_WIDTH-1:0]                           dispatch_tag,
    input  logic [COMMIT_TYPE_WIDTH-1:0]                        dispatch_commit_type,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0]                   dispatch_phy_reg,
    input  logic                                                complete_valid,
    input  logic [ROB_SIZE_WIDTH-1:0]                           complete_tag,
    input  logic                                                commit_stall,
    output logic [COMMIT_WIDTH-1:0]                             commit_valid,
    output logic [COMMIT_WIDTH-1:0][COMMIT_TYPE_WIDTH-1:0]      commit_type,
    output logic [COMMIT_WIDTH-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
    output logic                                                retire_tag_valid,
    output logic [ROB_SIZE_WIDTH-1:0]                           retire_tag,
    output logic [ROB_SIZE_WIDTH-1:0]                           head_tag,
    output logic                                                protocol_error
);

    // Handshake: dispatch_valid and complete_valid are single-cycle strobes with no
    // ready; the buffer accepts every strobe, and a strobe that hits an entry in the
    // wrong allocation state is dropped and latched into protocol_error. The commit
    // lanes are pure valid outputs; commit_stall is the only backpressure.

    localparam int ROB_DEPTH = 1 << ROB_SIZE_WIDTH;
    localparam int CNT_W     = $clog2(COMMIT_WIDTH + 1);

    logic [ROB_DEPTH-1:0]              alloc;
    logic [ROB_DEPTH-1:0]              done;
    logic [COMMIT_TYPE_WIDTH-1:0]      entry_type [ROB_DEPTH];
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] entry_reg  [ROB_DEPTH];
    logic [ROB_SIZE_WIDTH-1:0]         head;

    logic [ROB_SIZE_WIDTH-1:0]         lane_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]           lane_elig;
    logic [CNT_W-1:0]                  retire_cnt;
    logic [ROB_SIZE_WIDTH-1:0]         head_next;
    logic                              chain;

    assign head_tag = head;

    // A lane can only retire if every older lane retires too, so the retire set is
    // always a contiguous prefix starting at head.
    always_comb begin
        chain      = !commit_stall;
        retire_cnt = '0;
        lane_elig  = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_idx[i]  = head + ROB_SIZE_WIDTH'(i);
            chain        = chain && alloc[lane_idx[i]] && done[lane_idx[i]];
            lane_elig[i] = chain;
            if (chain) begin
                retire_cnt = retire_cnt + CNT_W'(1);
            end
        end
        head_next = head + ROB_SIZE_WIDTH'(retire_cnt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc                <= '0;
            done                 <= '0;
            head                 <= '0;
            commit_valid         <= '0;
            commit_type          <= '0;
            commited_wr_register <= '0;
            retire_tag_valid     <= 1'b0;
            retire_tag           <= '0;
            protocol_error       <= 1'b0;
        end else if (flush) begin
            alloc                <= '0;
            done                 <= '0;
            head                 <= '0;
            commit_valid         <= '0;
            commit_type          <= '0;
            commited_wr_register <= '0;
            retire_tag_valid     <= 1'b0;
            retire_tag           <= '0;
        end else begin
            // Completion precedes the retire clear, so a completion landing on a
            // retiring entry is absorbed without effect.
            if (complete_valid) begin
                if (alloc[complete_tag]) begin
                    done[complete_tag] <= 1'b1;
                end else begin
                    protocol_error <= 1'b1;
                end
            end

            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (lane_elig[i]) begin
                    alloc[lane_idx[i]] <= 1'b0;
                    done[lane_idx[i]]  <= 1'b0;
                end
                commit_valid[i]         <= lane_elig[i];
                commit_type[i]          <= lane_elig[i] ? entry_type[lane_idx[i]] : '0;
                commited_wr_register[i] <= lane_elig[i] ? entry_reg[lane_idx[i]] : '0;
            end

            // Dispatch last: it wins over a same-tag completion and leaves done clear.
            if (dispatch_valid) begin
                if (alloc[dispatch_tag]) begin
                    protocol_error <= 1'b1;
                end else begin
                    alloc[dispatch_tag] <= 1'b1;
                    done[dispatch_tag]  <= 1'b0;
                end
            end

            head             <= head_next;
            retire_tag_valid <= |lane_elig;
            retire_tag       <= (|lane_elig) ? head_next - ROB_SIZE_WIDTH'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && dispatch_valid && !alloc[dispatch_tag]) begin
            entry_type[dispatch_tag] <= dispatch_commit_type;
            entry_reg[dispatch_tag]  <= dispatch_phy_reg;
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: in-order, out-of-order, wrap, stall, flush and
// protocol-error scenarios, with hand-computed commit snapshots.
module tb_rob_commit_unit;

    localparam int RW     = 4;
    localparam int PW     = 6;
    localparam int CW     = 2;
    localparam int TW     = 2;
    localparam int SNAP_W = CW + CW * TW + CW * PW + 1 + RW;

    localparam logic [1:0] WB     = 2'd1;
    localparam logic [1:0] STORE  = 2'd2;
    localparam logic [1:0] BRANCH = 2'd3;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic                   dispatch_valid;
    logic [RW-1:0]          dispatch_tag;
    logic [TW-1:0]          dispatch_commit_type;
    logic [PW-1:0]          dispatch_phy_reg;
    logic                   complete_valid;
    logic [RW-1:0]          complete_tag;
    logic                   commit_stall;
    logic [CW-1:0]          commit_valid;
    logic [CW-1:0][TW-1:0]  commit_type;
    logic [CW-1:0][PW-1:0]  commited_wr_register;
    logic                   retire_tag_valid;
    logic [RW-1:0]          retire_tag;
    logic [RW-1:0]          head_tag;
    logic                   protocol_error;

    logic [SNAP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    rob_commit_unit #(
        .ROB_SIZE_WIDTH(RW),
        .PHYSICAL_REG_NUM_WIDTH(PW),
        .COMMIT_WIDTH(CW),
        .COMMIT_TYPE_WIDTH(TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .dispatch_valid(dispatch_valid),
        .dispatch_tag(dispatch_tag),
        .dispatch_commit_type(dispatch_commit_type),
        .dispatch_phy_reg(dispatch_phy_reg),
        .complete_valid(complete_valid),
        .complete_tag(complete_tag),
        .commit_stall(commit_stall),
        .commit_valid(commit_valid),
        .commit_type(commit_type),
        .commited_wr_register(commited_wr_register),
        .retire_tag_valid(retire_tag_valid),
        .retire_tag(retire_tag),
        .head_tag(head_tag),
        .protocol_error(protocol_error)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: one expected commit snapshot per checked cycle.
    task automatic expect_out(input string tag, input logic [1:0] v,
                              input logic [1:0] t1, input logic [1:0] t0,
                              input logic [5:0] r1, input logic [5:0] r0,
                              input logic rtv, input logic [3:0] rt);
        logic [SNAP_W-1:0] exp_w;
        logic [SNAP_W-1:0] obs_w;
        exp_w = {v, t1, t0, r1, r0, rtv, rtv ? rt : 4'd0};
        obs_w = {commit_valid, commit_type, commited_wr_register, retire_tag_valid,
                 rtv ? retire_tag : 4'd0};
        exp_q.push_back(exp_w);
        check(tag, 32'(obs_w), 32'(exp_q.pop_front()));
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 2'b00, 2'd0, 2'd0, 6'd0, 6'd0, 1'b0, 4'd0);
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge and are sampled
    // at the following edge; outputs are read right after that edge has passed.
    task automatic drive_cycle(input logic dv, input logic [3:0] dtag, input logic [1:0] dtype,
                               input logic [5:0] dreg, input logic cv, input logic [3:0] ctag,
                               input logic stall, input logic fl);
        dispatch_valid       = dv;
        dispatch_tag         = dtag;
        dispatch_commit_type = dtype;
        dispatch_phy_reg     = dreg;
        complete_valid       = cv;
        complete_tag         = ctag;
        commit_stall         = stall;
        flush                = fl;
        @(posedge clk);
        #1;
        dispatch_valid = 1'b0;
        complete_valid = 1'b0;
        commit_stall   = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic drive_dispatch(input logic [3:0] tag, input logic [1:0] ctype, input logic [5:0] preg);
        drive_cycle(1'b1, tag, ctype, preg, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic drive_complete(input logic [3:0] tag);
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, 1'b1, tag, 1'b0, 1'b0);
    endtask

    task automatic drive_idle();
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        flush                = 1'b0;
        dispatch_valid       = 1'b0;
        dispatch_tag         = '0;
        dispatch_commit_type = '0;
        dispatch_phy_reg     = '0;
        complete_valid       = 1'b0;
        complete_tag         = '0;
        commit_stall         = 1'b0;

        // Reset state
        do_reset();
        expect_idle("reset_outputs");
        check("reset_head", 32'(head_tag), 32'd0);
        check("reset_error", 32'(protocol_error), 32'd0);

        // Single in-order: 0 and 1 done together, 2 one cycle later
        drive_dispatch(4'd0, WB, 6'd10);
        drive_dispatch(4'd1, WB, 6'd11);
        drive_dispatch(4'd2, WB, 6'd12);
        drive_complete(4'd1);
        expect_idle("inorder_wait1");
        drive_complete(4'd0);
        expect_idle("inorder_wait0");
        drive_complete(4'd2);
        expect_out("inorder_pair", 2'b11, WB, WB, 6'd11, 6'd10, 1'b1, 4'd1);
        drive_idle();
        expect_out("inorder_single", 2'b01, 2'd0, WB, 6'd0, 6'd12, 1'b1, 4'd2);
        check("inorder_head", 32'(head_tag), 32'd3);

        // Asynchronous reset mid-operation, away from any clock edge
        reset = 1'b1;
        #2;
        expect_idle("async_reset_outputs");
        check("async_reset_head", 32'(head_tag), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Out-of-order completion: nothing retires until tag 0 is done
        do_reset();
        drive_dispatch(4'd0, WB, 6'd20);
        drive_dispatch(4'd1, STORE, 6'd21);
        drive_dispatch(4'd2, BRANCH, 6'd22);
        drive_dispatch(4'd3, WB, 6'd23);
        drive_complete(4'd3);
        expect_idle("ooo_c3");
        drive_complete(4'd2);
        expect_idle("ooo_c2");
        drive_complete(4'd1);
        expect_idle("ooo_c1");
        drive_complete(4'd0);
        expect_idle("ooo_c0");
        drive_idle();
        expect_out("ooo_first", 2'b11, STORE, WB, 6'd21, 6'd20, 1'b1, 4'd1);
        check("ooo_head_mid", 32'(head_tag), 32'd2);
        drive_idle();
        expect_out("ooo_second", 2'b11, WB, BRANCH, 6'd23, 6'd22, 1'b1, 4'd3);
        check("ooo_head_end", 32'(head_tag), 32'd4);
        drive_idle();
        expect_idle("ooo_drained");

        // Wrap-around: walk head to 14, then retire 14/15 and 0
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive_cycle(1'b1, 4'(i), WB, 6'(i), (i > 0), 4'((i > 0) ? i - 1 : 0), 1'b0, 1'b0);
        end
        drive_complete(4'd13);
        repeat (3) drive_idle();
        check("wrap_head_14", 32'(head_tag), 32'd14);
        drive_dispatch(4'd14, WB, 6'd30);
        drive_dispatch(4'd15, STORE, 6'd31);
        drive_dispatch(4'd0, WB, 6'd32);
        drive_complete(4'd15);
        expect_idle("wrap_c15");
        drive_complete(4'd14);
        expect_idle("wrap_c14");
        drive_complete(4'd0);
        expect_out("wrap_pair", 2'b11, STORE, WB, 6'd31, 6'd30, 1'b1, 4'd15);
        check("wrap_head_0", 32'(head_tag), 32'd0);
        drive_idle();
        expect_out("wrap_zero", 2'b01, 2'd0, WB, 6'd0, 6'd32, 1'b1, 4'd0);
        check("wrap_head_1", 32'(head_tag), 32'd1);
        check("wrap_error", 32'(protocol_error), 32'd0);

        // Stall: three stalled cycles with 0/1 done, then release
        do_reset();
        drive_dispatch(4'd0, WB, 6'd40);
        drive_dispatch(4'd1, WB, 6'd41);
        drive_complete(4'd0);
        expect_idle("stall_pre");
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, 1'b1, 4'd1, 1'b1, 1'b0);
        expect_idle("stall_1");
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        expect_idle("stall_2");
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        expect_idle("stall_3");
        check("stall_head", 32'(head_tag), 32'd0);
        // Release cycle also re-completes tag 0 while it retires: must not flag an error
        drive_complete(4'd0);
        expect_out("stall_release", 2'b11, WB, WB, 6'd41, 6'd40, 1'b1, 4'd1);
        check("stall_late_complete_error", 32'(protocol_error), 32'd0);

        // Flush: 5 allocated, 1 and 2 done; flush cycle also carries dispatch 5 / complete 0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_dispatch(4'(i), WB, 6'(50 + i));
        end
        drive_complete(4'd1);
        expect_idle("flush_pre1");
        drive_complete(4'd2);
        expect_idle("flush_pre2");
        drive_cycle(1'b1, 4'd5, WB, 6'd55, 1'b1, 4'd0, 1'b0, 1'b1);
        expect_idle("flush_outputs");
        check("flush_head", 32'(head_tag), 32'd0);
        drive_dispatch(4'd0, WB, 6'd56);
        expect_idle("flush_fresh_dispatch");
        check("flush_fresh_error", 32'(protocol_error), 32'd0);
        drive_complete(4'd0);
        expect_idle("flush_fresh_complete");
        drive_idle();
        expect_out("flush_fresh_commit", 2'b01, 2'd0, WB, 6'd0, 6'd56, 1'b1, 4'd0);
        drive_dispatch(4'd5, WB, 6'd57);
        check("flush_dropped_dispatch", 32'(protocol_error), 32'd0);

        // Protocol error: double dispatch keeps the original entry, error is sticky
        do_reset();
        drive_dispatch(4'd0, WB, 6'd60);
        check("perr_clean", 32'(protocol_error), 32'd0);
        drive_dispatch(4'd0, STORE, 6'd61);
        check("perr_double_dispatch", 32'(protocol_error), 32'd1);
        drive_complete(4'd0);
        drive_idle();
        expect_out("perr_original_entry", 2'b01, 2'd0, WB, 6'd0, 6'd60, 1'b1, 4'd0);
        drive_cycle(1'b0, 4'd0, 2'd0, 6'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("perr_sticky_flush", 32'(protocol_error), 32'd1);
        do_reset();
        check("perr_cleared_by_reset", 32'(protocol_error), 32'd0);
        drive_complete(4'd7);
        check("perr_unalloc_complete", 32'(protocol_error), 32'd1);

        // Same-cycle dispatch and completion of one tag: dispatch wins, done stays 0
        do_reset();
        drive_cycle(1'b1, 4'd0, WB, 6'd62, 1'b1, 4'd0, 1'b0, 1'b0);
        check("same_cycle_error", 32'(protocol_error), 32'd1);
        drive_idle();
        expect_idle("same_cycle_not_done1");
        drive_idle();
        expect_idle("same_cycle_not_done2");
        drive_complete(4'd0);
        expect_idle("same_cycle_complete");
        drive_idle();
        expect_out("same_cycle_commit", 2'b01, 2'd0, WB, 6'd0, 6'd62, 1'b1, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
